// File: rtl/ysyx_23060075_ifu_prefetch_pkg.sv
// Shared ISA constants and sizing helpers for the fetch unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ysyx_23060075_ifu_prefetch_pkg;

  localparam int          ISA_WIDTH        = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int          INST_BYTES       = 4;

  // Drop counter must cover DEPTH in-flight responses, hence one bit above the pointer width.
  function automatic int drop_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ysyx_23060075_ifu_slot_queue.sv
// In-order slot queue: PCs allocated at issue, filled by responses, released to decode.
// Latency: a fill becomes visible on the head outputs the edge after it is written.
// Backpressure: none internally; the caller keeps alloc within DEPTH free slots.
module ysyx_23060075_ifu_slot_queue
  import ysyx_23060075_ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = ISA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill,
  input  logic [XLEN-1:0]          fill_inst,
  input  logic                     fill_err,
  input  logic                     retire,
  output logic                     head_filled,
  output logic [XLEN-1:0]          head_pc,
  output logic [XLEN-1:0]          head_inst,
  output logic                     head_err,
  output logic [$clog2(DEPTH):0]   alloc_cnt,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            filled;
    logic            err;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } slot_t;

  slot_t         slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] fptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
    end else begin
      if (retire) begin
        slots[head].filled <= 1'b0;
        head               <= head + PW'(1);
      end
      if (alloc) begin
        slots[tail] <= '{filled: 1'b0, err: 1'b0, pc: alloc_pc, inst: '0};
        tail        <= tail + PW'(1);
      end
      // Responses return in request order, so fill simply trails tail.
      if (fill) begin
        slots[fptr].filled <= 1'b1;
        slots[fptr].inst   <= fill_inst;
        slots[fptr].err    <= fill_err;
        fptr               <= fptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(alloc) - CW'(retire);
      pend_cnt  <= pend_cnt + CW'(alloc) - CW'(fill);
    end
  end

  assign head_filled = slots[head].filled;
  assign head_pc     = slots[head].pc;
  assign head_inst   = slots[head].inst;
  assign head_err    = slots[head].err;

endmodule

// File: rtl/ysyx_23060075_ifu_prefetch.sv
// Prefetching IFU: issues sequential fetches ahead of decode and queues results in order.
// Latency: request registered one edge after credit frees; response reaches out_* one edge after acceptance.
// Backpressure: out_ready stalls the queue; issue stops when live slots plus dropped responses reach DEPTH.
module ysyx_23060075_ifu_prefetch
  import ysyx_23060075_ifu_prefetch_pkg::*;
#(
  parameter int              XLEN     = ISA_WIDTH,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_err
);

  localparam int          CW        = drop_cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic            req_vld_nxt;
  logic            stale_req;
  logic            stale_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   alloc_cnt;
  logic [CW-1:0]   pend_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW:0]     credit;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_live;
  logic            out_fire;
  logic            alloc;

  always_comb begin
    req_fire  = mem_req_valid && mem_req_ready;
    resp_drop = mem_resp_valid && (drop_cnt != '0);
    resp_live = mem_resp_valid && (drop_cnt == '0);
    out_fire  = out_valid && out_ready;
    // A request accepted on a redirect edge, or one held across an earlier redirect, is stale.
    alloc     = req_fire && !stale_req && !redirect_valid;

    drop_nxt = drop_cnt - CW'(resp_drop) + CW'(req_fire && (stale_req || redirect_valid));
    if (redirect_valid) begin
      drop_nxt = drop_nxt + pend_cnt - CW'(resp_live);
    end

    cnt_nxt   = redirect_valid ? '0 : alloc_cnt + CW'(alloc) - CW'(out_fire);
    stale_nxt = redirect_valid ? (mem_req_valid && !mem_req_ready) : (stale_req && !req_fire);

    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = redirect_pc & ~XLEN'(INST_BYTES - 1);
    end else if (alloc) begin
      fetch_pc_nxt = fetch_pc + XLEN'(INST_BYTES);
    end

    credit      = {1'b0, cnt_nxt} + {1'b0, drop_nxt};
    req_vld_nxt = mem_req_valid;
    addr_nxt    = mem_req_addr;
    if (!(mem_req_valid && !mem_req_ready)) begin
      req_vld_nxt = !redirect_valid && (credit < DEPTH_LIM);
      addr_nxt    = fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= RESET_PC;
      fetch_pc      <= RESET_PC;
      drop_cnt      <= '0;
      stale_req     <= 1'b0;
    end else begin
      mem_req_valid <= req_vld_nxt;
      mem_req_addr  <= addr_nxt;
      fetch_pc      <= fetch_pc_nxt;
      drop_cnt      <= drop_nxt;
      stale_req     <= stale_nxt;
      if (mem_resp_valid) begin
        assert (drop_cnt != '0 || pend_cnt != '0);
      end
    end
  end

  ysyx_23060075_ifu_slot_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_slot_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .alloc       (alloc),
    .alloc_pc    (mem_req_addr),
    .fill        (resp_live),
    .fill_inst   (mem_resp_data),
    .fill_err    (mem_resp_err),
    .retire      (out_fire),
    .head_filled (out_valid),
    .head_pc     (out_pc),
    .head_inst   (out_inst),
    .head_err    (out_err),
    .alloc_cnt   (alloc_cnt),
    .pend_cnt    (pend_cnt)
  );

endmodule

// File: tb/tb_ysyx_23060075_ifu_prefetch.sv
// Directed bench for the prefetching IFU with an in-order memory model (data = ~addr).
module tb_ysyx_23060075_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        resp_en;
  logic [31:0] err_addr;
  logic [31:0] mem_a;
  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  logic [31:0] out_pc_q[$];
  logic [31:0] out_inst_q[$];
  logic        out_err_q[$];
  int          out_cyc_q[$];

  ysyx_23060075_ifu_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory answers one cycle after each accepted request; handshakes are logged here too.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
    end else begin
      if (resp_en && mq.size() > 0) begin
        mem_a          = mq.pop_front();
        mem_resp_valid = 1'b1;
        mem_resp_data  = ~mem_a;
        mem_resp_err   = (mem_a == err_addr);
      end else begin
        mem_resp_valid = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        mq.push_back(mem_req_addr);
        req_log.push_back(mem_req_addr);
      end
      if (out_valid && out_ready) begin
        out_pc_q.push_back(out_pc);
        out_inst_q.push_back(out_inst);
        out_err_q.push_back(out_err);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_logs(input int nreq, input int nout, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (req_log.size() >= nreq && out_pc_q.size() >= nout) break;
      tick();
    end
  endtask

  // Leaves rst_n released at posedge+1; the first request rises on the next edge.
  task automatic do_reset(input logic rdy, input logic ordy, input logic ren);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = rdy;
    out_ready      = ordy;
    resp_en        = ren;
    tick();
    tick();
    req_log.delete();
    out_pc_q.delete();
    out_inst_q.delete();
    out_err_q.delete();
    out_cyc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    resp_en       = 1'b1;
    tick();
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_req_addr: got %h want 80000000", mem_req_addr); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    vectors++; if (out_inst !== 32'h0) begin miscompares++; $display("FAIL rst_out_inst: got %h want 0", out_inst); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL rst_out_err: got %b want 0", out_err); end
    do_reset(1'b1, 1'b1, 1'b1);
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rel_req_valid_pre: got %b want 0", mem_req_valid); end
    tick();
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rel_req_valid: got %b want 1", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rel_req_addr: got %h want 80000000", mem_req_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1, 1'b1);
    wait_logs(8, 8, 40);
    vectors++; if (out_pc_q.size() < 8) begin miscompares++; $display("FAIL stream_timeout: got %0d outputs want 8", out_pc_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (req_log[i] !== 32'h8000_0000 + 32'(4 * i)) begin miscompares++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], 32'h8000_0000 + 32'(4 * i)); end
      vectors++; if (out_pc_q[i] !== 32'h8000_0000 + 32'(4 * i)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc_q[i], 32'h8000_0000 + 32'(4 * i)); end
      vectors++; if (out_inst_q[i] !== ~(32'h8000_0000 + 32'(4 * i))) begin miscompares++; $display("FAIL stream_inst[%0d]: got %h want %h", i, out_inst_q[i], ~(32'h8000_0000 + 32'(4 * i))); end
    end
    for (int i = 0; i < 7; i++) begin
      vectors++; if (out_cyc_q[i + 1] - out_cyc_q[i] != 1) begin miscompares++; $display("FAIL stream_gap[%0d]: got %0d cycles want 1", i, out_cyc_q[i + 1] - out_cyc_q[i]); end
    end
  endtask

  task automatic test_full();
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (12) tick();
    vectors++; if (req_log.size() != 4) begin miscompares++; $display("FAIL full_req_count: got %0d want 4", req_log.size()); end
    vectors++; if (req_log[3] !== 32'h8000_000C) begin miscompares++; $display("FAIL full_last_req: got %h want 8000000c", req_log[3]); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
    tick();
    tick();
    vectors++; if (out_pc !== 32'h8000_0000) begin miscompares++; $display("FAIL full_hold_pc: got %h want 80000000", out_pc); end
    vectors++; if (out_inst !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL full_hold_inst: got %h want 7fffffff", out_inst); end
    out_ready = 1'b1;
    wait_logs(5, 8, 30);
    vectors++; if (req_log[4] !== 32'h8000_0010) begin miscompares++; $display("FAIL full_resume_req: got %h want 80000010", req_log[4]); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (out_pc_q[i] !== 32'h8000_0000 + 32'(4 * i)) begin miscompares++; $display("FAIL full_out_pc[%0d]: got %h want %h", i, out_pc_q[i], 32'h8000_0000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset(1'b1, 1'b1, 1'b0);
    wait_logs(2, 0, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    vectors++; if (req_log.size() != 3) begin miscompares++; $display("FAIL drop_req_count: got %0d want 3", req_log.size()); end
    vectors++; if (req_log[2] !== 32'h8000_0008) begin miscompares++; $display("FAIL drop_third_req: got %h want 80000008", req_log[2]); end
    wait_logs(4, 1, 30);
    vectors++; if (req_log[3] !== 32'h8000_0100) begin miscompares++; $display("FAIL drop_new_req: got %h want 80000100", req_log[3]); end
    vectors++; if (out_pc_q[0] !== 32'h8000_0100) begin miscompares++; $display("FAIL drop_first_pc: got %h want 80000100", out_pc_q[0]); end
    vectors++; if (out_inst_q[0] !== 32'h7FFF_FEFF) begin miscompares++; $display("FAIL drop_first_inst: got %h want 7ffffeff", out_inst_q[0]); end
  endtask

  task automatic test_redirect_held();
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h8000_0004) break;
      tick();
    end
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL held_valid: got %b want 1", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL held_addr: got %h want 80000004", mem_req_addr); end
    repeat (3) tick();
    vectors++; if (mem_req_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL held_addr_late: got %h want 80000004", mem_req_addr); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL held_out_valid: got %b want 0", out_valid); end
    mem_req_ready = 1'b1;
    wait_logs(3, 1, 30);
    vectors++; if (req_log[1] !== 32'h8000_0004) begin miscompares++; $display("FAIL held_stale_req: got %h want 80000004", req_log[1]); end
    vectors++; if (req_log[2] !== 32'h8000_0200) begin miscompares++; $display("FAIL held_next_req: got %h want 80000200", req_log[2]); end
    vectors++; if (out_pc_q[0] !== 32'h8000_0200) begin miscompares++; $display("FAIL held_first_pc: got %h want 80000200", out_pc_q[0]); end
  endtask

  task automatic test_err();
    err_addr = 32'h8000_0008;
    do_reset(1'b1, 1'b1, 1'b1);
    wait_logs(4, 4, 30);
    vectors++; if (out_pc_q[2] !== 32'h8000_0008) begin miscompares++; $display("FAIL err_pc: got %h want 80000008", out_pc_q[2]); end
    vectors++; if (out_err_q[2] !== 1'b1) begin miscompares++; $display("FAIL err_flag: got %b want 1", out_err_q[2]); end
    vectors++; if (out_err_q[1] !== 1'b0) begin miscompares++; $display("FAIL err_prev: got %b want 0", out_err_q[1]); end
    vectors++; if (out_err_q[3] !== 1'b0) begin miscompares++; $display("FAIL err_next: got %b want 0", out_err_q[3]); end
    err_addr = 32'h1;
  endtask

  task automatic test_wrap_and_reset();
    do_reset(1'b1, 1'b1, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    wait_logs(3, 2, 30);
    vectors++; if (req_log[1] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req0: got %h want fffffffc", req_log[1]); end
    vectors++; if (req_log[2] !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_req1: got %h want 00000000", req_log[2]); end
    vectors++; if (out_pc_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc0: got %h want fffffffc", out_pc_q[0]); end
    vectors++; if (out_pc_q[1] !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_pc1: got %h want 00000000", out_pc_q[1]); end
    vectors++; if (out_inst_q[1] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_inst1: got %h want ffffffff", out_inst_q[1]); end
    tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (mem_req_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL midrst_req_addr: got %h want 80000000", mem_req_addr); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_out_pc: got %h want 0", out_pc); end
    vectors++; if (out_inst !== 32'h0) begin miscompares++; $display("FAIL midrst_out_inst: got %h want 0", out_inst); end
    do_reset(1'b1, 1'b1, 1'b1);
    wait_logs(1, 1, 20);
    vectors++; if (req_log[0] !== 32'h8000_0000) begin miscompares++; $display("FAIL restart_req: got %h want 80000000", req_log[0]); end
    vectors++; if (out_pc_q[0] !== 32'h8000_0000) begin miscompares++; $display("FAIL restart_pc: got %h want 80000000", out_pc_q[0]); end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    resp_en        = 1'b0;
    err_addr       = 32'h1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_held();
    test_err();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
